series_mux_loader: RTL

SERIES_MUX_LOADER -- requirements
Module: series_mux_loader

---
 rtl/series_mux_pkg.sv | 14 +
 rtl/series_mux_loader.sv | 114 +++++++++++
 2 files changed

// File: rtl/series_mux_pkg.sv
// Shared sizing and state encoding for the series mux loader.
package series_mux_pkg;

    localparam int N     = 100;
    localparam int CHUNK = 4;
    localparam int BEATS = N / CHUNK;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/series_mux_loader.sv
// Series mux loader: assembles an N-bit In/Sel pair from CHUNK-wide beats,
// LSB-first, and commits the whole pair atomically to the downstream mux.
// Malformed frames (s_last on the wrong beat) are discarded with frame_err;
// flush discards a partial frame silently.
module series_mux_loader
    import series_mux_pkg::state_t;
    import series_mux_pkg::IDLE;
    import series_mux_pkg::LOAD;
    import series_mux_pkg::COMMIT;
#(
    parameter int N     = series_mux_pkg::N,
    parameter int CHUNK = series_mux_pkg::CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [CHUNK-1:0] s_data,
    input  logic [CHUNK-1:0] s_sel,
    input  logic             s_last,
    input  logic             flush,
    output logic [N-1:0]     mux_in,
    output logic [N-1:0]     mux_sel,
    output logic             commit,
    output logic             frame_err
);

    localparam int FRAME_BEATS = N / CHUNK;
    localparam int CW          = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BEATS - 1);

    // A frame must tile the vector exactly; reject bad parameter sets early.
    if ((N % CHUNK) != 0) begin : g_bad_params
        $error("series_mux_loader: N must be a multiple of CHUNK");
    end

    state_t          state_reg;
    logic [CW-1:0]   count_reg;
    logic [N-1:0]    shadow_data_reg;
    logic [N-1:0]    shadow_sel_reg;
    logic [N-1:0]    merged_data;
    logic [N-1:0]    merged_sel;
    logic            accept;
    logic            final_beat;

    // Flush wins over a simultaneous beat, so that beat is never taken.
    assign accept     = s_valid && s_ready && !flush;
    assign final_beat = (count_reg == LAST_IDX);

    // Shadow contents with the current beat dropped into its chunk slot.
    for (genvar gi = 0; gi < FRAME_BEATS; gi++) begin : g_merge
        assign merged_data[gi*CHUNK +: CHUNK] =
            (count_reg == CW'(gi)) ? s_data : shadow_data_reg[gi*CHUNK +: CHUNK];
        assign merged_sel[gi*CHUNK +: CHUNK] =
            (count_reg == CW'(gi)) ? s_sel : shadow_sel_reg[gi*CHUNK +: CHUNK];
    end

    // Frame FSM with registered handshake, commit and error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            shadow_data_reg <= '0;
            shadow_sel_reg  <= '0;
            mux_in          <= '0;
            mux_sel         <= '0;
            commit          <= 1'b0;
            frame_err       <= 1'b0;
            s_ready         <= 1'b0;
        end else begin
            commit    <= 1'b0;
            frame_err <= 1'b0;
            case (state_reg)
                COMMIT: begin
                    // Commit already landed; a flush here has nothing to discard.
                    state_reg <= IDLE;
                    s_ready   <= 1'b1;
                end
                default: begin
                    s_ready <= 1'b1;
                    if (flush) begin
                        state_reg       <= IDLE;
                        count_reg       <= '0;
                        shadow_data_reg <= '0;
                        shadow_sel_reg  <= '0;
                    end else if (accept) begin
                        if (final_beat && s_last) begin
                            mux_in          <= merged_data;
                            mux_sel         <= merged_sel;
                            commit          <= 1'b1;
                            s_ready         <= 1'b0;
                            state_reg       <= COMMIT;
                            count_reg       <= '0;
                            shadow_data_reg <= '0;
                            shadow_sel_reg  <= '0;
                        end else if (final_beat || s_last) begin
                            frame_err       <= 1'b1;
                            state_reg       <= IDLE;
                            count_reg       <= '0;
                            shadow_data_reg <= '0;
                            shadow_sel_reg  <= '0;
                        end else begin
                            shadow_data_reg <= merged_data;
                            shadow_sel_reg  <= merged_sel;
                            count_reg       <= count_reg + CW'(1);
                            state_reg       <= LOAD;
                        end
                    end
                end
            endcase
        end
    end

endmodule
